// File: rtl/rename_issue_stage.sv
// rename_issue_stage
//   Front end of the out-of-order pipe, directly upstream of the reservation
//   station. It holds the architectural register file, the register status
//   table (reg -> pending producer tag) and the tag free list. It renames each
//   accepted instruction into one registered reservation-station write, and
//   it snoops the CDB to retire results into the register file and free tags.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready      decoded-instruction handshake (in_ready is comb)
//   in_rs, in_rt, in_rd      source 1, source 2 and destination registers
//   in_wr_rd, in_control     destination write enable, ALU control
//   rs_write                 one-cycle RS write strobe, the cycle after accept
//   rs_val{1,2}_r            operand value valid (else wait on rs_tag{1,2})
//   rs_val{1,2}, rs_tag{1,2} operand values / producer tags
//   rs_dest, rs_control      allocated destination tag (0 = none), ALU control
//   rs_release               RS entries dispatched this cycle (0..2)
//   cdb_valid/tag/value      result broadcast
//   credits                  free RS entries
module rename_issue_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TAG_W    = 5,
    parameter int unsigned NUM_TAGS = 16,
    parameter int unsigned RS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic              in_wr_rd,
    input  logic [5:0]        in_control,
    output logic              rs_write,
    output logic              rs_val1_r,
    output logic              rs_val2_r,
    output logic [DATA_W-1:0] rs_val1,
    output logic [DATA_W-1:0] rs_val2,
    output logic [TAG_W-1:0]  rs_tag1,
    output logic [TAG_W-1:0]  rs_tag2,
    output logic [TAG_W-1:0]  rs_dest,
    output logic [5:0]        rs_control,
    input  logic [1:0]        rs_release,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    output logic [2:0]        credits
);

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned IDX_W    = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

    typedef struct packed {
        logic              rdy;
        logic [DATA_W-1:0] val;
        logic [TAG_W-1:0]  tag;
    } op_t;

    logic [DATA_W-1:0]   regfile [NUM_REGS];
    logic [TAG_W-1:0]    status  [NUM_REGS];
    logic [NUM_TAGS-1:0] free_q;
    logic [2:0]          credits_q;

    logic                need_tag;
    logic                have_free;
    logic [TAG_W-1:0]    alloc_tag;
    logic [NUM_TAGS-1:0] alloc_mask;
    logic [NUM_TAGS-1:0] cdb_mask;
    logic                cdb_live;
    logic                accept;
    logic                do_alloc;
    logic [3:0]          cred_sum;
    op_t                 op1;
    op_t                 op2;

    // Operand resolution against the pre-cycle status table, with CDB bypass.
    function automatic op_t lookup(input logic [4:0]        r,
                                   input logic [TAG_W-1:0]  st,
                                   input logic [DATA_W-1:0] rf);
        op_t o;
        o.rdy = 1'b1;
        o.val = '0;
        o.tag = '0;
        if (r != 5'd0) begin
            if (st == '0) begin
                o.val = rf;
            end else if (cdb_valid && cdb_tag == st) begin
                o.val = cdb_value;
            end else begin
                o.rdy = 1'b0;
                o.tag = st;
            end
        end
        return o;
    endfunction

    // Lowest free tag, plus a one-hot of the CDB tag if it is currently
    // allocated; a result for a free or out-of-range tag is dropped entirely.
    always_comb begin
        have_free  = 1'b0;
        alloc_tag  = '0;
        alloc_mask = '0;
        cdb_mask   = '0;
        for (int unsigned t = 1; t < NUM_TAGS; t++) begin
            if (free_q[IDX_W'(t)] && !have_free) begin
                have_free                = 1'b1;
                alloc_tag                = TAG_W'(t);
                alloc_mask[IDX_W'(t)]    = 1'b1;
            end
            if (cdb_valid && cdb_tag == TAG_W'(t) && !free_q[IDX_W'(t)])
                cdb_mask[IDX_W'(t)] = 1'b1;
        end
    end

    assign cdb_live = |cdb_mask;
    assign need_tag = in_wr_rd && (in_rd != 5'd0);
    assign in_ready = (credits_q != 3'd0) && (!need_tag || have_free);
    assign accept   = in_valid && in_ready;
    assign do_alloc = accept && need_tag;
    assign credits  = credits_q;

    always_comb begin
        op1 = lookup(in_rs, status[in_rs], regfile[in_rs]);
        op2 = lookup(in_rt, status[in_rt], regfile[in_rt]);
    end

    always_comb begin
        cred_sum = {1'b0, credits_q} - {3'b000, accept} + {2'b00, rs_release};
        if (cred_sum > 4'(RS_DEPTH))
            cred_sum = 4'(RS_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regfile[5'(r)] <= '0;
                status[5'(r)]  <= '0;
            end
            free_q     <= {{(NUM_TAGS-1){1'b1}}, 1'b0};
            credits_q  <= 3'(RS_DEPTH);
            rs_write   <= 1'b0;
            rs_val1_r  <= 1'b0;
            rs_val2_r  <= 1'b0;
            rs_val1    <= '0;
            rs_val2    <= '0;
            rs_tag1    <= '0;
            rs_tag2    <= '0;
            rs_dest    <= '0;
            rs_control <= '0;
        end else begin
            // Retire first; a same-cycle rename of the same register is
            // assigned afterwards so its new tag wins while the value lands.
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (cdb_live && status[5'(r)] == cdb_tag) begin
                    regfile[5'(r)] <= cdb_value;
                    status[5'(r)]  <= '0;
                end
            end
            if (do_alloc)
                status[in_rd] <= alloc_tag;

            free_q    <= (free_q & ~(do_alloc ? alloc_mask : '0)) | cdb_mask;
            credits_q <= cred_sum[2:0];
            rs_write  <= accept;

            if (accept) begin
                rs_val1_r  <= op1.rdy;
                rs_val2_r  <= op2.rdy;
                rs_val1    <= op1.val;
                rs_val2    <= op2.val;
                rs_tag1    <= op1.tag;
                rs_tag2    <= op2.tag;
                rs_dest    <= do_alloc ? alloc_tag : '0;
                rs_control <= in_control;
            end
        end
    end

endmodule

// File: tb/tb_rename_issue_stage.sv
module tb_rename_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic        in_wr_rd;
    logic [5:0]  in_control;
    logic        rs_write, rs_val1_r, rs_val2_r;
    logic [31:0] rs_val1, rs_val2;
    logic [4:0]  rs_tag1, rs_tag2, rs_dest;
    logic [5:0]  rs_control;
    logic [1:0]  rs_release;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [2:0]  credits;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        v1r, v2r;
        logic [31:0] v1, v2;
        logic [4:0]  t1, t2, d;
        logic [5:0]  c;
    } exp_t;

    exp_t sb[$];

    rename_issue_stage #(.DATA_W(32), .TAG_W(5), .NUM_TAGS(16), .RS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_wr_rd(in_wr_rd),
        .in_control(in_control), .rs_write(rs_write), .rs_val1_r(rs_val1_r),
        .rs_val2_r(rs_val2_r), .rs_val1(rs_val1), .rs_val2(rs_val2),
        .rs_tag1(rs_tag1), .rs_tag2(rs_tag2), .rs_dest(rs_dest),
        .rs_control(rs_control), .rs_release(rs_release), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_value(cdb_value), .credits(credits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic v1r, input logic [31:0] v1, input logic [4:0] t1,
                                input logic v2r, input logic [31:0] v2, input logic [4:0] t2,
                                input logic [4:0] d, input logic [5:0] c);
        exp_t e;
        e.v1r = v1r; e.v1 = v1; e.t1 = t1;
        e.v2r = v2r; e.v2 = v2; e.t2 = t2;
        e.d = d; e.c = c;
        return e;
    endfunction

    // Scoreboard: every RS write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rs_write) begin
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("val1_r",  32'(rs_val1_r),  32'(e.v1r));
                chk("val2_r",  32'(rs_val2_r),  32'(e.v2r));
                chk("val1",    rs_val1,         e.v1);
                chk("val2",    rs_val2,         e.v2);
                chk("tag1",    32'(rs_tag1),    32'(e.t1));
                chk("tag2",    32'(rs_tag2),    32'(e.t2));
                chk("dest",    32'(rs_dest),    32'(e.d));
                chk("control", 32'(rs_control), 32'(e.c));
            end
        end
    end

    // Drive one instruction for one cycle (from a negedge), require acceptance.
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic wr, input logic [5:0] ctrl, input exp_t e);
        in_valid = 1'b1; in_rs = rs; in_rt = rt; in_rd = rd; in_wr_rd = wr; in_control = ctrl;
        #1;
        chk("in_ready_on_issue", 32'(in_ready), 32'd1);
        if (in_ready) sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0; in_wr_rd = 1'b0;
    endtask

    task automatic idle(input logic [1:0] rel, input logic cv, input logic [4:0] ct, input logic [31:0] cval);
        rs_release = rel; cdb_valid = cv; cdb_tag = ct; cdb_value = cval;
        @(negedge clk);
        rs_release = 2'd0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0; in_wr_rd = 1'b0;
        in_control = '0; rs_release = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rs_write", 32'(rs_write), 32'd0);
        chk("rst_credits",  32'(credits),  32'd4);
        chk("rst_dest",     32'(rs_dest),  32'd0);
        chk("rst_val1",     rs_val1,       32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Basic rename, then dependent issue.
        issue(5'd1, 5'd2, 5'd3, 1'b1, 6'h11, mk(1, 0, 0, 1, 0, 0, 5'd1, 6'h11));
        chk("credits_after_first", 32'(credits), 32'd3);
        issue(5'd3, 5'd0, 5'd4, 1'b1, 6'h02, mk(0, 0, 5'd1, 1, 0, 0, 5'd2, 6'h02));
        idle(2'd2, 1'b1, 5'd1, 32'hDEAD);
        chk("credits_refill", 32'(credits), 32'd4);
        issue(5'd3, 5'd4, 5'd0, 1'b1, 6'h03, mk(1, 32'hDEAD, 0, 0, 0, 5'd2, 5'd0, 6'h03));
        issue(5'd0, 5'd0, 5'd6, 1'b1, 6'h04, mk(1, 0, 0, 1, 0, 0, 5'd1, 6'h04));

        // CDB bypass in the issue cycle; tag 1 not reallocatable that cycle.
        cdb_valid = 1'b1; cdb_tag = 5'd1; cdb_value = 32'h55;
        issue(5'd6, 5'd3, 5'd7, 1'b1, 6'h05, mk(1, 32'h55, 0, 1, 32'hDEAD, 0, 5'd3, 6'h05));
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        idle(2'd2, 1'b0, 5'd0, 0);
        idle(2'd2, 1'b0, 5'd0, 0);
        chk("credits_full", 32'(credits), 32'd4);

        // Credit exhaustion.
        for (int i = 0; i < 4; i++)
            issue(5'd6, 5'd0, 5'd0, 1'b0, 6'(i), mk(1, 32'h55, 0, 1, 0, 0, 5'd0, 6'(i)));
        in_valid = 1'b1; in_rs = 5'd1; in_rd = 5'd0; in_wr_rd = 1'b0;
        #1;
        chk("in_ready_no_credit", 32'(in_ready), 32'd0);
        chk("credits_zero",       32'(credits),  32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        idle(2'd1, 1'b0, 5'd0, 0);
        #1;
        chk("in_ready_one_credit", 32'(in_ready), 32'd1);
        @(negedge clk);
        idle(2'd2, 1'b0, 5'd0, 0);
        idle(2'd2, 1'b0, 5'd0, 0);

        // Tag exhaustion: tags 2,3 are held; allocate the remaining 13.
        rs_release = 2'd1;
        for (int i = 0; i < 13; i++)
            issue(5'd0, 5'd0, 5'(8 + i), 1'b1, 6'h20,
                  mk(1, 0, 0, 1, 0, 0, (i == 0) ? 5'd1 : 5'(i + 3), 6'h20));
        rs_release = 2'd0;
        in_valid = 1'b1; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd21; in_wr_rd = 1'b1;
        #1;
        chk("in_ready_no_tag", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("no_write_no_tag", 32'(rs_write), 32'd0);
        in_valid = 1'b0; in_wr_rd = 1'b0;
        issue(5'd0, 5'd0, 5'd21, 1'b0, 6'h21, mk(1, 0, 0, 1, 0, 0, 5'd0, 6'h21));
        idle(2'd1, 1'b1, 5'd7, 32'h77);
        issue(5'd12, 5'd0, 5'd22, 1'b1, 6'h22, mk(1, 32'h77, 0, 1, 0, 0, 5'd7, 6'h22));

        // Stale result after a re-rename must not disturb the newer mapping.
        idle(2'd1, 1'b1, 5'd1, 32'h1);
        idle(2'd1, 1'b1, 5'd2, 32'h2);
        issue(5'd0, 5'd0, 5'd5, 1'b1, 6'h30, mk(1, 0, 0, 1, 0, 0, 5'd1, 6'h30));
        issue(5'd0, 5'd0, 5'd5, 1'b1, 6'h31, mk(1, 0, 0, 1, 0, 0, 5'd2, 6'h31));
        idle(2'd2, 1'b1, 5'd1, 32'hBAD);
        issue(5'd5, 5'd5, 5'd0, 1'b0, 6'h32, mk(0, 0, 5'd2, 0, 0, 5'd2, 5'd0, 6'h32));
        issue(5'd0, 5'd0, 5'd23, 1'b1, 6'h33, mk(1, 0, 0, 1, 0, 0, 5'd1, 6'h33));

        // Reset mid-stream with a valid instruction present.
        rst = 1'b1; in_valid = 1'b1; in_rs = 5'd3; in_rd = 5'd9; in_wr_rd = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 5'd2; cdb_value = 32'h99;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_wr_rd = 1'b0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        #1;
        chk("mid_rst_write",   32'(rs_write), 32'd0);
        chk("mid_rst_credits", 32'(credits),  32'd4);
        chk("mid_rst_dest",    32'(rs_dest),  32'd0);
        @(negedge clk);
        issue(5'd3, 5'd5, 5'd3, 1'b1, 6'h3F, mk(1, 0, 0, 1, 0, 0, 5'd1, 6'h3F));
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
